// File: rtl/iomem_initiator.sv
// iomem_initiator: single-outstanding iomem bus master with valid/ready command and response ports.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wstrb carry the command
//   rsp_valid/rsp_ready    response handshake; rsp_rdata, rsp_err carry the result
//   busy                   high whenever a command is in flight
//   iomem_*                bus request (valid, addr, wdata, wstrb) and completion (ready, rdata)
module iomem_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  // The counter holds the number of REQ cycles already completed, so the
  // timeout fires at the end of the TIMEOUT_CYCLES-th REQ cycle.
  wire timeout = (TIMEOUT_CYCLES != 0) && (cnt == LAST);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      iomem_valid <= 1'b0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      iomem_wstrb <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          iomem_addr  <= cmd_addr & 32'hFFFF_FFFC;
          iomem_wstrb <= cmd_write ? cmd_wstrb : 4'b0000;
          iomem_wdata <= cmd_write ? cmd_wdata : '0;
          cnt         <= '0;
          cmd_ready   <= 1'b0;
          busy        <= 1'b1;
          if (cmd_write && cmd_wstrb == 4'b0000) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state       <= REQ;
            iomem_valid <= 1'b1;
          end
        end
        REQ: if (iomem_ready || timeout) begin
          state       <= RSP;
          iomem_valid <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_err     <= !iomem_ready;
          // A zero bus strobe marks a read; writes and timeouts return zero.
          rsp_rdata   <= (iomem_ready && iomem_wstrb == 4'b0000) ? iomem_rdata : '0;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
        RSP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
